// File: rtl/zfa_pkg.sv
// Shared definitions for the Zfa FLI constant path: formats, field geometry,
// FLI table indices and the unpacked-operand record used by matcher and checker.
package zfa_pkg;

    typedef enum logic [1:0] {
        HALF   = 2'b00,
        SINGLE = 2'b01,
        DOUBLE = 2'b10,
        BF16   = 2'b11
    } fmt_e;

    localparam int H_EXP_W = 5;
    localparam int H_MAN_W = 10;
    localparam int H_BIAS  = 15;
    localparam int S_EXP_W = 8;
    localparam int S_MAN_W = 23;
    localparam int S_BIAS  = 127;
    localparam int D_EXP_W = 11;
    localparam int D_MAN_W = 52;
    localparam int D_BIAS  = 1023;
    localparam int B_EXP_W = 8;
    localparam int B_MAN_W = 7;
    localparam int B_BIAS  = 127;

    localparam logic [4:0] FLI_IDX_NEG_ONE  = 5'd0;
    localparam logic [4:0] FLI_IDX_MIN_NORM = 5'd1;
    localparam logic [4:0] FLI_IDX_QUARTER  = 5'd8;
    localparam logic [4:0] FLI_IDX_HALF     = 5'd12;
    localparam logic [4:0] FLI_IDX_ONE      = 5'd16;
    localparam logic [4:0] FLI_IDX_TWO      = 5'd20;
    localparam logic [4:0] FLI_IDX_INF      = 5'd30;
    localparam logic [4:0] FLI_IDX_CNAN     = 5'd31;

    // exp is the unbiased exponent in 12-bit two's complement
    typedef struct packed {
        logic        sign;
        logic [11:0] exp;
        logic [1:0]  m2;
        logic        tail_zero;
        logic        zero;
        logic        subnormal;
        logic        inf;
        logic        qnan_canonical;
        logic        min_normal;
        logic        illegal;
    } fp_unpacked_t;

endpackage

// File: rtl/zfa_fp_unpack.sv
// Combinational operand unpack: format select, NaN-box check and classification.
// Mantissas are left-aligned into 52 bits so m2/tail are format independent.
module zfa_fp_unpack
    import zfa_pkg::*;
#(
    parameter int IN_WIDTH = 64
) (
    input  logic [IN_WIDTH-1:0] value_i,
    input  fmt_e                fmt_i,
    input  logic                nan_boxing_i,
    output fp_unpacked_t        op_o
);

    localparam bit DBL_OK = (IN_WIDTH == 64);

    logic [63:0] val64;
    logic        sign;
    logic [10:0] bexp;
    logic [10:0] emax;
    logic [11:0] bias;
    logic [51:0] man;
    logic        box_ok;
    logic        man_zero;
    logic        exp_ones;

    always_comb begin
        val64                 = '1;
        val64[IN_WIDTH-1:0]   = value_i;
        sign   = 1'b0;
        bexp   = '0;
        emax   = '1;
        bias   = '0;
        man    = '0;
        box_ok = 1'b1;
        case (fmt_i)
            HALF: begin
                box_ok = !nan_boxing_i || (&val64[63:16]);
                sign   = val64[15];
                bexp   = 11'(val64[14:10]);
                emax   = 11'((1 << H_EXP_W) - 1);
                bias   = 12'(H_BIAS);
                man    = {val64[9:0], 42'd0};
            end
            SINGLE: begin
                box_ok = !nan_boxing_i || (&val64[63:32]);
                sign   = val64[31];
                bexp   = 11'(val64[30:23]);
                emax   = 11'((1 << S_EXP_W) - 1);
                bias   = 12'(S_BIAS);
                man    = {val64[22:0], 29'd0};
            end
            DOUBLE: begin
                sign   = val64[63];
                bexp   = val64[62:52];
                emax   = 11'((1 << D_EXP_W) - 1);
                bias   = 12'(D_BIAS);
                man    = val64[51:0];
            end
            default: begin
                box_ok = !nan_boxing_i || (&val64[63:16]);
                sign   = val64[15];
                bexp   = 11'(val64[14:7]);
                emax   = 11'((1 << B_EXP_W) - 1);
                bias   = 12'(B_BIAS);
                man    = {val64[6:0], 45'd0};
            end
        endcase

        // A broken NaN box reads as the canonical quiet NaN of the format
        if (!box_ok) begin
            sign = 1'b0;
            bexp = emax;
            man  = {1'b1, 51'd0};
        end

        man_zero = (man == '0);
        exp_ones = (bexp == emax);

        op_o                = '0;
        op_o.sign           = sign;
        op_o.exp            = (bexp == '0) ? (12'd1 - bias) : ({1'b0, bexp} - bias);
        op_o.m2             = man[51:50];
        op_o.tail_zero      = (man[49:0] == '0);
        op_o.zero           = (bexp == '0) && man_zero;
        op_o.subnormal      = (bexp == '0) && !man_zero;
        op_o.inf            = exp_ones && man_zero;
        op_o.qnan_canonical = exp_ones && !sign && (man == {1'b1, 51'd0});
        op_o.min_normal     = (bexp == 11'd1) && man_zero;
        op_o.illegal        = (fmt_i == DOUBLE) && !DBL_OK;
    end

endmodule

// File: rtl/zfa_fli_index_matcher.sv
// Two-stage valid/ready pipeline mapping an FP operand back to its Zfa FLI index.
// Stage 1 registers the unpacked operand, stage 2 registers the table lookup.
module zfa_fli_index_matcher
    import zfa_pkg::*;
#(
    parameter int IN_WIDTH = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [IN_WIDTH-1:0] value_i,
    input  logic [1:0]          type_data_i,
    input  logic                nan_boxing_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                match_o,
    output logic [4:0]          imm_sel_o
);

    fp_unpacked_t op_d;
    fp_unpacked_t s1_op_q;
    logic         s1_valid_q;
    logic         s2_valid_q;
    logic         s1_ready;
    logic         s2_ready;
    logic         match_d;
    logic         match_q;
    logic [4:0]   idx_d;
    logic [4:0]   idx_q;

    zfa_fp_unpack #(.IN_WIDTH(IN_WIDTH)) u_unpack (
        .value_i      (value_i),
        .fmt_i        (fmt_e'(type_data_i)),
        .nan_boxing_i (nan_boxing_i),
        .op_o         (op_d)
    );

    always_comb begin
        match_d = 1'b0;
        idx_d   = '0;
        if (!s1_op_q.illegal) begin
            if (s1_op_q.qnan_canonical) begin
                match_d = 1'b1;
                idx_d   = FLI_IDX_CNAN;
            end else if (s1_op_q.inf) begin
                match_d = !s1_op_q.sign;
                idx_d   = s1_op_q.sign ? 5'd0 : FLI_IDX_INF;
            end else if (s1_op_q.subnormal) begin
                // Only half reaches exponent -14 as a subnormal: 2^-16 and 2^-15
                if (!s1_op_q.sign && s1_op_q.tail_zero && (s1_op_q.exp == 12'(-14))
                    && (s1_op_q.m2 == 2'b01 || s1_op_q.m2 == 2'b10)) begin
                    match_d = 1'b1;
                    idx_d   = (s1_op_q.m2 == 2'b01) ? 5'd2 : 5'd3;
                end
            end else if (!s1_op_q.zero && s1_op_q.tail_zero) begin
                if (s1_op_q.min_normal) begin
                    match_d = !s1_op_q.sign;
                    idx_d   = s1_op_q.sign ? 5'd0 : FLI_IDX_MIN_NORM;
                end else if (s1_op_q.sign) begin
                    match_d = (s1_op_q.exp == 12'd0) && (s1_op_q.m2 == 2'b00);
                    idx_d   = FLI_IDX_NEG_ONE;
                end else begin
                    case (s1_op_q.exp)
                        12'd0: begin
                            match_d = 1'b1;
                            idx_d   = FLI_IDX_ONE + {3'd0, s1_op_q.m2};
                        end
                        12'(-1): begin
                            match_d = 1'b1;
                            idx_d   = FLI_IDX_HALF + {3'd0, s1_op_q.m2};
                        end
                        12'(-2): begin
                            match_d = 1'b1;
                            idx_d   = FLI_IDX_QUARTER + {3'd0, s1_op_q.m2};
                        end
                        12'd1: begin
                            match_d = (s1_op_q.m2 != 2'b11);
                            idx_d   = match_d ? (FLI_IDX_TWO + {3'd0, s1_op_q.m2}) : 5'd0;
                        end
                        default: begin
                            match_d = (s1_op_q.m2 == 2'b00);
                            case (s1_op_q.exp)
                                12'd2:    idx_d = 5'd23;
                                12'd3:    idx_d = 5'd24;
                                12'd4:    idx_d = 5'd25;
                                12'd7:    idx_d = 5'd26;
                                12'd8:    idx_d = 5'd27;
                                12'd15:   idx_d = 5'd28;
                                12'd16:   idx_d = 5'd29;
                                12'(-3):  idx_d = 5'd7;
                                12'(-4):  idx_d = 5'd6;
                                12'(-7):  idx_d = 5'd5;
                                12'(-8):  idx_d = 5'd4;
                                12'(-15): idx_d = 5'd3;
                                12'(-16): idx_d = 5'd2;
                                default:  match_d = 1'b0;
                            endcase
                            if (!match_d) begin
                                idx_d = '0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign s2_ready = !s2_valid_q || ready_i;
    assign s1_ready = !s1_valid_q || s2_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            match_q    <= 1'b0;
            idx_q      <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid_q <= valid_i;
            end
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_ready && s1_valid_q) begin
                match_q <= match_d;
                idx_q   <= idx_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (s1_ready && valid_i) begin
            s1_op_q <= op_d;
        end
    end

    assign ready_o   = s1_ready;
    assign valid_o   = s2_valid_q;
    assign match_o   = match_q;
    assign imm_sel_o = idx_q;

endmodule

// File: tb/tb_zfa_fli_index_matcher.sv
// Bench for the FLI index matcher: directed table points, backpressure, reset,
// and random operands scored against a real-valued FLI table model.
module tb_zfa_fli_index_matcher;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] value_i = '0;
    logic [1:0]   type_data_i = '0;
    logic         nan_boxing_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic         match_o;
    logic [4:0]   imm_sel_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;

    typedef struct {
        logic [63:0] val;
        logic [1:0]  fmt;
        logic        nb;
        logic        em;
        logic [4:0]  ei;
    } stim_t;

    typedef struct {
        logic       em;
        logic [4:0] ei;
        int         acc;
        int         md;
    } exp_t;

    stim_t pend[$];
    exp_t  sb[$];
    logic       hold_vld = 1'b0;
    logic       hold_m;
    logic [4:0] hold_i;

    zfa_fli_index_matcher #(.IN_WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .value_i      (value_i),
        .type_data_i  (type_data_i),
        .nan_boxing_i (nan_boxing_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .match_o      (match_o),
        .imm_sel_o    (imm_sel_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, want, cyc);
        end
    endtask

    function automatic void geom(input logic [1:0] f, output int ew, output int mw,
                                 output int bias, output int fw);
        case (f)
            2'b00:   begin ew = 5;  mw = 10; bias = 15;   fw = 16; end
            2'b01:   begin ew = 8;  mw = 23; bias = 127;  fw = 32; end
            2'b10:   begin ew = 11; mw = 52; bias = 1023; fw = 64; end
            default: begin ew = 8;  mw = 7;  bias = 127;  fw = 16; end
        endcase
    endfunction

    function automatic real fli_val(input int i, input int bias);
        case (i)
            0:  return -1.0;
            1:  return 2.0 ** (1 - bias);
            2:  return 2.0 ** (-16);
            3:  return 2.0 ** (-15);
            4:  return 2.0 ** (-8);
            5:  return 2.0 ** (-7);
            6:  return 0.0625;
            7:  return 0.125;
            8:  return 0.25;
            9:  return 0.3125;
            10: return 0.375;
            11: return 0.4375;
            12: return 0.5;
            13: return 0.625;
            14: return 0.75;
            15: return 0.875;
            16: return 1.0;
            17: return 1.25;
            18: return 1.5;
            19: return 1.75;
            20: return 2.0;
            21: return 2.5;
            22: return 3.0;
            23: return 4.0;
            24: return 8.0;
            25: return 16.0;
            26: return 128.0;
            27: return 256.0;
            28: return 32768.0;
            29: return 65536.0;
            default: return 0.0;
        endcase
    endfunction

    // Decode the operand to a real number and look it up in the FLI value table
    function automatic void ref_model(input logic [63:0] v, input logic [1:0] f, input logic nb,
                                      output logic m, output logic [4:0] ix);
        int ew, mw, bias, fw, bexp;
        logic s;
        logic [63:0] mant;
        real val;
        m  = 1'b0;
        ix = 5'd0;
        geom(f, ew, mw, bias, fw);
        if (f == 2'b10 && W < 64) return;
        if (nb && fw < 64 && ((v >> fw) != ({64{1'b1}} >> fw))) begin
            m = 1'b1; ix = 5'd31; return;
        end
        s    = v[fw-1];
        bexp = int'((v >> mw) & ((64'd1 << ew) - 64'd1));
        mant = v & ((64'd1 << mw) - 64'd1);
        if (bexp == (1 << ew) - 1) begin
            if (mant == 0) begin
                if (!s) begin m = 1'b1; ix = 5'd30; end
            end else if (!s && mant == (64'd1 << (mw - 1))) begin
                m = 1'b1; ix = 5'd31;
            end
            return;
        end
        if (bexp == 0) val = real'(mant) / (2.0 ** mw) * (2.0 ** (1 - bias));
        else           val = (1.0 + real'(mant) / (2.0 ** mw)) * (2.0 ** (bexp - bias));
        if (s) val = -val;
        for (int i = 0; i < 30; i++) begin
            if (val == fli_val(i, bias)) begin
                m = 1'b1; ix = 5'(i);
            end
        end
    endfunction

    function automatic stim_t gen_rand();
        stim_t st;
        int ew, mw, bias, fw, emax, bexp, k, e;
        logic s;
        logic [63:0] mant, bits, upper;
        st.fmt = 2'($urandom_range(0, 3));
        geom(st.fmt, ew, mw, bias, fw);
        emax = (1 << ew) - 1;
        s    = ($urandom_range(0, 5) == 0);
        k    = $urandom_range(0, 15);
        mant = 64'd0;
        bexp = 0;
        case (k)
            0: bexp = 0;
            1: begin
                case ($urandom_range(0, 2))
                    0: mant = 64'd1 << (mw - 1);
                    1: mant = 64'd1 << (mw - 2);
                    default: mant = (({32'($urandom), 32'($urandom)}) & ((64'd1 << mw) - 1)) | 64'd1;
                endcase
            end
            2: bexp = emax;
            3: begin
                bexp = emax;
                mant = 64'd1 << (mw - 1);
                if ($urandom_range(0, 1) == 1) mant = mant | (64'd1 << $urandom_range(0, mw - 2));
            end
            4: begin
                bexp = 1;
                if ($urandom_range(0, 2) == 0) mant = 64'd1;
            end
            default: begin
                e    = int'($urandom_range(0, 36)) - 18;
                bexp = e + bias;
                if (bexp < 1 || bexp >= emax) bexp = bias;
                mant = 64'($urandom_range(0, 3)) << (mw - 2);
                if ($urandom_range(0, 4) == 0) mant = mant | (64'd1 << $urandom_range(0, mw - 3));
            end
        endcase
        bits = (64'(s) << (ew + mw)) | (64'(bexp) << mw) | mant;
        st.nb = 1'($urandom_range(0, 1));
        if (fw < 64) begin
            upper = ($urandom_range(0, 4) == 0) ? {32'($urandom), 32'($urandom)} : {64{1'b1}};
            st.val = (upper << fw) | bits;
        end else begin
            st.val = bits;
        end
        ref_model(st.val, st.fmt, st.nb, st.em, st.ei);
        return st;
    endfunction

    task automatic add(input logic [63:0] v, input logic [1:0] f, input logic nb,
                       input logic em, input logic [4:0] ei);
        stim_t st;
        st.val = v; st.fmt = f; st.nb = nb; st.em = em; st.ei = ei;
        pend.push_back(st);
    endtask

    task automatic step();
        bit rst_now = rst_i;
        bit bubble  = (mode == 2) && ($urandom_range(0, 3) == 0);
        if (!rst_now && pend.size() > 0 && !bubble) begin
            valid_i      = 1'b1;
            value_i      = pend[0].val;
            type_data_i  = pend[0].fmt;
            nan_boxing_i = pend[0].nb;
        end else begin
            valid_i      = 1'b0;
            value_i      = {32'($urandom), 32'($urandom)};
            type_data_i  = 2'($urandom_range(0, 3));
            nan_boxing_i = 1'($urandom_range(0, 1));
        end
        ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        @(negedge clk);
        if (rst_now) begin
            sb.delete();
            hold_vld = 1'b0;
        end else begin
            chk("ready_o", ready_o, !(sb.size() == 2 && !ready_i));
            if (sb.size() == 0) chk("idle_valid_o", valid_o, 0);
            if (sb.size() == 2) chk("full_valid_o", valid_o, 1);
            if (hold_vld) begin
                chk("hold_valid_o", valid_o, 1);
                chk("hold_match_o", match_o, hold_m);
                chk("hold_imm_sel_o", imm_sel_o, hold_i);
            end
            if (!match_o) chk("nomatch_imm_zero", imm_sel_o, 0);
            if (valid_o && ready_i && sb.size() > 0) begin
                exp_t e = sb.pop_front();
                chk("match_o", match_o, e.em);
                chk("imm_sel_o", imm_sel_o, e.ei);
                if (e.md == 0) chk("latency", 64'(cyc - e.acc), 2);
                else           chk("latency_min", (cyc - e.acc) >= 2, 1);
            end
            hold_vld = valid_o && !ready_i;
            hold_m   = match_o;
            hold_i   = imm_sel_o;
            if (valid_i && ready_o) begin
                sb.push_back('{pend[0].em, pend[0].ei, cyc, mode});
                void'(pend.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_now) begin
            chk("rst_valid_o", valid_o, 0);
            chk("rst_match_o", match_o, 0);
            chk("rst_imm_sel_o", imm_sel_o, 0);
            chk("rst_ready_o", ready_o, 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        mode = 0;
        while ((pend.size() > 0 || sb.size() > 0) && n < 200) begin
            step();
            n++;
        end
        chk("drain_done", 64'(pend.size() + sb.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;

        mode = 0;
        add(64'hBFF0000000000000, 2'b10, 1'b0, 1'b1, 5'd0);
        add(64'hFFFFFFFF3EA00000, 2'b01, 1'b1, 1'b1, 5'd9);
        add(64'hFFFFFFFFFFFF3EA0, 2'b11, 1'b1, 1'b1, 5'd9);
        add(64'hFFFFFFFFFFFF0200, 2'b00, 1'b1, 1'b1, 5'd3);
        add(64'hFFFFFFFFFFFF0100, 2'b00, 1'b1, 1'b1, 5'd2);
        add(64'hFFFFFFFFFFFF0400, 2'b00, 1'b1, 1'b1, 5'd1);
        add(64'hFFFFFFFFFFFF7C00, 2'b00, 1'b1, 1'b1, 5'd30);
        add(64'hFFFFFFFFFFFF7E01, 2'b00, 1'b1, 1'b0, 5'd0);
        add(64'h000000003F800000, 2'b01, 1'b1, 1'b1, 5'd31);
        add(64'h000000003F800000, 2'b01, 1'b0, 1'b1, 5'd16);
        add(64'h3FF4000000000001, 2'b10, 1'b0, 1'b0, 5'd0);
        add(64'hFFFFFFFF40E00000, 2'b01, 1'b1, 1'b0, 5'd0);
        add(64'hFFFFFFFFBF800000, 2'b01, 1'b1, 1'b1, 5'd0);
        add(64'h7FF8000000000000, 2'b10, 1'b0, 1'b1, 5'd31);
        add(64'h7FF0000000000000, 2'b10, 1'b0, 1'b1, 5'd30);
        add(64'hFFF0000000000000, 2'b10, 1'b0, 1'b0, 5'd0);
        add(64'hFFFFFFFF47800000, 2'b01, 1'b1, 1'b1, 5'd29);
        add(64'hFFFFFFFF00800000, 2'b01, 1'b1, 1'b1, 5'd1);
        add(64'h3FC0000000000000, 2'b10, 1'b0, 1'b1, 5'd7);
        add(64'h3FB0000000000000, 2'b10, 1'b0, 1'b1, 5'd6);
        add(64'hFFFFFFFFFFFF5C00, 2'b00, 1'b1, 1'b1, 5'd27);
        add(64'h0000000000003F80, 2'b11, 1'b0, 1'b1, 5'd16);
        drain();

        mode = 1;
        add(64'hFFFFFFFF3EA00000, 2'b01, 1'b1, 1'b1, 5'd9);
        add(64'hFFFFFFFFFFFF7C00, 2'b00, 1'b1, 1'b1, 5'd30);
        add(64'hBFF0000000000000, 2'b10, 1'b0, 1'b1, 5'd0);
        add(64'h3FF4000000000001, 2'b10, 1'b0, 1'b0, 5'd0);
        repeat (6) step();
        chk("bp_accepted", 64'(sb.size()), 2);
        chk("bp_ready_o", ready_o, 0);
        drain();

        mode = 1;
        add(64'hFFFFFFFF47800000, 2'b01, 1'b1, 1'b1, 5'd29);
        add(64'hFFFFFFFF00800000, 2'b01, 1'b1, 1'b1, 5'd1);
        for (int i = 0; i < 6 && sb.size() < 2; i++) step();
        chk("rst_inflight", 64'(sb.size()), 2);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        mode = 0;
        repeat (8) step();

        mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if (pend.size() < 3) pend.push_back(gen_rand());
            step();
        end
        drain();

        mode = 0;
        for (int i = 0; i < 300; i++) begin
            if (pend.size() < 2) pend.push_back(gen_rand());
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
